dm_port_arbiter: RTL
====================

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 7, word address width of data memory (128 words).
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter STARVE_MAX, default 4, loader-waiting cycles before it preempts the CPU.
REQ-004 Parameter MAX_BURST, default 4, loader beats before it yields to a pending CPU request.
REQ-005 Ports, in order:
- `clk`: in, 1; the only clock, rising edge.
- `rst`: in, 1; asynchronous, active-low reset.
- `cpu_req`: in, 1; MEM-stage access request.
- `cpu_we`: in, 1; MEM-stage write enable.
- `cpu_addr`: in, ADDR_W; MEM-stage word address.
- `cpu_wdata`: in, DATA_W; MEM-stage store data.
- `cpu_rdata`: out, DATA_W; load data to the MEM stage.
- `cpu_stall`: out, 1; freeze the pipeline.
- `ld_req`, `ld_we`, `ld_addr`, `ld_wdata`: in, 1/1/ADDR_W/DATA_W; loader request, write enable, address and data.
- `ld_gnt`: out, 1; loader beat accepted this cycle.
- `ld_rvalid`: out, 1; loader read data valid.
- `ld_rdata`: out, DATA_W; loader read data.
- `dm_we`: out, 1; memory write enable.
- `dm_addr`: out, ADDR_W; memory address.
- `dm_wdata`: out, DATA_W; memory write data.
- `dm_rdata`: in, DATA_W; memory read data, 1-cycle latency.
- `stat_stall_cnt`: out, 32; CPU stall-cycle count.
- `stat_ld_beats`: out, 32; loader beat count.

Function
REQ-006 The FSM SHALL have two states: OWN_CPU (reset state) and OWN_LD.
REQ-007 In OWN_CPU the block SHALL drive `dm_we`/`dm_addr`/`dm_wdata` combinationally from the `cpu_*` inputs (dm_we = cpu_req & cpu_we), with `cpu_stall`=0 and `ld_gnt`=0.
REQ-008 In OWN_LD the block SHALL drive memory from the `ld_*` inputs (dm_we = ld_req & ld_we), with `ld_gnt`=ld_req and `cpu_stall`=cpu_req.
REQ-009 `starve_cnt`:
- Increments each OWN_CPU cycle in which ld_req & cpu_req are both high.
- Saturates at STARVE_MAX-1.
- Clears on entry to OWN_LD.
REQ-010 OWN_CPU→OWN_LD SHALL occur at a clock edge when ld_req=1 and (cpu_req=0 or starve_cnt=STARVE_MAX-1).
REQ-011 When cpu_req and ld_req are both high with starve_cnt<STARVE_MAX-1, the CPU SHALL win.
REQ-012 `beat_cnt`:
- Increments on each ld_gnt cycle in OWN_LD.
- Saturates at MAX_BURST-1.
- Clears on entry to OWN_LD.
REQ-013 OWN_LD→OWN_CPU SHALL occur when ld_req=0, or when cpu_req=1 and beat_cnt=MAX_BURST-1; with no CPU request pending, the loader SHALL keep the port indefinitely.
REQ-014 `cpu_rdata` SHALL equal `dm_rdata` unconditionally; CPU read timing matches a directly attached memory.
REQ-015 `ld_rvalid` SHALL be a register set one cycle after a cycle with ld_gnt & ~ld_we, else 0; `ld_rdata`=dm_rdata.
REQ-016 A write beat SHALL complete in its grant cycle; no write is buffered or dropped.
REQ-017 Worst-case CPU stall SHALL be MAX_BURST cycles per arbitration round; worst-case loader wait SHALL be STARVE_MAX cycles.

Reset
REQ-018 rst=0 SHALL immediately set the following, including mid-burst:
- state to OWN_CPU
- starve_cnt, beat_cnt, ld_rvalid and both stat counters to 0
- ld_gnt and cpu_stall to 0 (both driven from state)
REQ-019 Any in-flight loader read SHALL be abandoned at reset, with no ld_rvalid afterwards.

Configuration
REQ-020 With DM_ARB_STATS_EN defined, `stat_stall_cnt` SHALL count cycles with cpu_stall=1 and `stat_ld_beats` SHALL count ld_gnt cycles; both are 32-bit wrapping counters.
REQ-021 Without DM_ARB_STATS_EN, both stat outputs SHALL be tied to 0 and no counter flops SHALL be inferred.

Structure
REQ-022 Package dm_arb_pkg SHALL hold the state enum type (OWN_CPU, OWN_LD) and the default STARVE_MAX and MAX_BURST constants.
REQ-023 The stats counters SHALL live in sub-module dm_arb_stats, instantiated only under DM_ARB_STATS_EN.

Verification (STARVE_MAX=4, MAX_BURST=4)
REQ-024 CPU alone: cpu_req=1, cpu_we=1, addr=5, wdata=0x00001234 → same-cycle dm_we=1, dm_addr=5; cpu_stall=0 throughout.
REQ-025 Loader alone, 6 writes to addr 0..5, cpu_req=0 → ld_gnt high for 6 consecutive cycles, no yield; DM[0..5] are written.
REQ-026 Both requesting continuously → ownership alternates: 4 CPU cycles then 4 loader cycles; each cpu_stall pulse lasts exactly 4 cycles.
REQ-027 With DM[0]=9 preloaded, a loader read of addr 0 → ld_rvalid=1 exactly one cycle after ld_gnt, with ld_rdata=0x00000009.
REQ-028 rst=0 asserted at the 2nd beat of a loader burst → next cycle: state OWN_CPU, ld_gnt=0, ld_rvalid=0, counters 0; a CPU write proceeds immediately after release.
REQ-029 With DM_ARB_STATS_EN defined, the REQ-026 traffic run for 16 cycles → stat_stall_cnt=8 and stat_ld_beats=8; without the macro both read 0.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and default arbitration limits for the data-memory port arbiter.
package dm_arb_pkg;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_LD  = 1'b1
  } arb_state_e;

  localparam int DEF_STARVE_MAX = 4;
  localparam int DEF_MAX_BURST  = 4;

endpackage

// File: rtl/dm_arb_stats.sv
// Wrapping 32-bit activity counters for the data-memory port arbiter.
module dm_arb_stats (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stall,
  input  logic        ld_gnt,
  output logic [31:0] stat_stall_cnt,
  output logic [31:0] stat_ld_beats
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_stall_cnt <= '0;
      stat_ld_beats  <= '0;
    end else begin
      if (cpu_stall) stat_stall_cnt <= stat_stall_cnt + 32'd1;
      if (ld_gnt)    stat_ld_beats  <= stat_ld_beats + 32'd1;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Shares one data-memory port between the CPU MEM stage and a loader.
// Define DM_ARB_STATS_EN to build the stall/beat statistics counters.
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = DEF_STARVE_MAX,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic [31:0]       stat_stall_cnt,
  output logic [31:0]       stat_ld_beats
);

  localparam int CNT_MAX = (STARVE_MAX > MAX_BURST) ? STARVE_MAX : MAX_BURST;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX - 1);
  localparam logic [CW-1:0] BURST_LIM  = CW'(MAX_BURST - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v,
                                            input logic [CW-1:0] lim);
    return (v >= lim) ? lim : v + CW'(1);
  endfunction

  arb_state_e    state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic [CW-1:0] beat_cnt;
  logic          starve_sat;
  logic          beat_sat;
  logic          enter_ld;
  logic          rd_vld_p1;

  assign starve_sat = (starve_cnt == STARVE_LIM);
  assign beat_sat   = (beat_cnt == BURST_LIM);
  assign enter_ld   = (state == OWN_CPU) && (state_nxt == OWN_LD);

  always_comb begin
    state_nxt = state;
    dm_we     = 1'b0;
    dm_addr   = cpu_addr;
    dm_wdata  = cpu_wdata;
    cpu_stall = 1'b0;
    ld_gnt    = 1'b0;
    case (state)
      OWN_CPU: begin
        dm_we = cpu_req & cpu_we;
        if (ld_req && (!cpu_req || starve_sat)) state_nxt = OWN_LD;
      end
      OWN_LD: begin
        dm_we     = ld_req & ld_we;
        dm_addr   = ld_addr;
        dm_wdata  = ld_wdata;
        ld_gnt    = ld_req;
        cpu_stall = cpu_req;
        // An idle CPU never forces a yield, so a lone loader streams freely.
        if (!ld_req || (cpu_req && beat_sat)) state_nxt = OWN_CPU;
      end
      default: state_nxt = OWN_CPU;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= OWN_CPU;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else if (enter_ld) begin
      starve_cnt <= '0;
      beat_cnt   <= '0;
    end else if (state == OWN_CPU) begin
      if (cpu_req && ld_req) starve_cnt <= sat_inc(starve_cnt, STARVE_LIM);
    end else if (ld_gnt) begin
      beat_cnt <= sat_inc(beat_cnt, BURST_LIM);
    end
  end

  // Read data returns one cycle after the granted read beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_vld_p1 <= 1'b0;
    else      rd_vld_p1 <= ld_gnt & ~ld_we;
  end

  assign ld_rvalid = rd_vld_p1;
  assign ld_rdata  = dm_rdata;
  assign cpu_rdata = dm_rdata;

`ifdef DM_ARB_STATS_EN
  dm_arb_stats u_stats (
    .clk            (clk),
    .rst            (rst),
    .cpu_stall      (cpu_stall),
    .ld_gnt         (ld_gnt),
    .stat_stall_cnt (stat_stall_cnt),
    .stat_ld_beats  (stat_ld_beats)
  );
`else
  assign stat_stall_cnt = 32'd0;
  assign stat_ld_beats  = 32'd0;
`endif

endmodule
